// File: rtl/uart_tx_pkg.sv
// Shared types and encodings for the UART transmit frame controller.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_t;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_DATA  = 2'b01;
  localparam logic [1:0] SEL_PAR   = 2'b10;
  localparam logic [1:0] SEL_STOP  = 2'b11;

  function automatic logic [1:0] sel_of(input tx_state_t st);
    case (st)
      ST_START:  sel_of = SEL_START;
      ST_DATA:   sel_of = SEL_DATA;
      ST_PARITY: sel_of = SEL_PAR;
      default:   sel_of = SEL_STOP;
    endcase
  endfunction

  function automatic int cnt_width(input int w);
    cnt_width = (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Payload parity: XOR-reduce, inverted when odd parity is selected.
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  odd,
  output logic                  par
);

  assign par = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer driving the output mux; all outputs are flops.
// Optional feature: define UART_TX_STOP2_EN for the Stop2 port and a second stop bit.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_STOP2_EN
  input  logic                  Stop2,
`endif
  output logic [1:0]            MUX_Sel,
  output logic                  Ser_Data,
  output logic                  PAR_bit,
  output logic                  Busy
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_t               state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0]   data_r, data_s;
  logic                    par_en_r, par_en_s;
  logic                    par_bit_r, par_bit_s;
  logic                    par_calc_s;
  logic                    accept_s, last_stop_s;
  logic                    ser_s;
  logic [1:0]              mux_sel_r;
  logic                    ser_data_r, busy_r;
`ifdef UART_TX_STOP2_EN
  logic                    stop2_r, stop2_s;
`endif

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data (P_DATA),
    .odd  (PAR_TYP),
    .par  (par_calc_s)
  );

  // A new byte may be taken from idle or from the final stop bit (no idle gap).
  always_comb begin
`ifdef UART_TX_STOP2_EN
    last_stop_s = ((state_r == ST_STOP) && !stop2_r) || (state_r == ST_STOP2);
`else
    last_stop_s = (state_r == ST_STOP);
`endif
    accept_s = Data_Valid && ((state_r == ST_IDLE) || last_stop_s);
  end

  // Next-state, counter and latch logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    data_s    = data_r;
    par_en_s  = par_en_r;
    par_bit_s = par_bit_r;
`ifdef UART_TX_STOP2_EN
    stop2_s   = stop2_r;
`endif
    if (accept_s) begin
      data_s    = P_DATA;
      par_en_s  = PAR_EN;
      par_bit_s = par_calc_s;
`ifdef UART_TX_STOP2_EN
      stop2_s   = Stop2;
`endif
    end else begin
      data_s    = data_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
      ST_START: begin
        state_s = ST_DATA;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          state_s = par_en_r ? ST_PARITY : ST_STOP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_PARITY: state_s = ST_STOP;
      ST_STOP: begin
`ifdef UART_TX_STOP2_EN
        if (stop2_r)       state_s = ST_STOP2;
        else if (accept_s) state_s = ST_START;
        else               state_s = ST_IDLE;
`else
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
`endif
      end
`ifdef UART_TX_STOP2_EN
      ST_STOP2: begin
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
`endif
      default: state_s = ST_IDLE;
    endcase

    if (state_s == ST_DATA) ser_s = data_s[cnt_s];
    else                    ser_s = 1'b0;
  end

  // State, payload and output registers; outputs are decoded from next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      data_r     <= {DATA_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      mux_sel_r  <= SEL_STOP;
      ser_data_r <= 1'b0;
      busy_r     <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_r    <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      data_r     <= data_s;
      par_en_r   <= par_en_s;
      par_bit_r  <= par_bit_s;
      mux_sel_r  <= sel_of(state_s);
      ser_data_r <= ser_s;
      busy_r     <= (state_s != ST_IDLE);
`ifdef UART_TX_STOP2_EN
      stop2_r    <= stop2_s;
`endif
    end
  end

  assign MUX_Sel  = mux_sel_r;
  assign Ser_Data = ser_data_r;
  assign PAR_bit  = par_bit_r;
  assign Busy     = busy_r;

endmodule
